// File: rtl/core_pipe_exec_mdu_issue_if.sv
// Request/response bus between the execute-stage issue logic and the multiply/divide unit.
// The MDU holds mdu_ready/mdu_rd until it sees mdu_flush.
interface core_pipe_exec_mdu_issue_if #(
   parameter int unsigned XLEN = 64
);
   logic            mdu_valid;
   logic            mdu_op_word;
   logic            mdu_op_mul;
   logic            mdu_op_mulh;
   logic            mdu_op_mulhu;
   logic            mdu_op_mulhsu;
   logic            mdu_op_div;
   logic            mdu_op_divu;
   logic            mdu_op_rem;
   logic            mdu_op_remu;
   logic [XLEN-1:0] mdu_rs1;
   logic [XLEN-1:0] mdu_rs2;
   logic            mdu_flush;
   logic            mdu_ready;
   logic [XLEN-1:0] mdu_rd;

   modport master (
      output mdu_valid, mdu_op_word, mdu_op_mul, mdu_op_mulh, mdu_op_mulhu, mdu_op_mulhsu,
             mdu_op_div, mdu_op_divu, mdu_op_rem, mdu_op_remu, mdu_rs1, mdu_rs2, mdu_flush,
      input  mdu_ready, mdu_rd
   );

   modport slave (
      input  mdu_valid, mdu_op_word, mdu_op_mul, mdu_op_mulh, mdu_op_mulhu, mdu_op_mulhsu,
             mdu_op_div, mdu_op_divu, mdu_op_rem, mdu_op_remu, mdu_rs1, mdu_rs2, mdu_flush,
      output mdu_ready, mdu_rd
   );
endinterface

// File: rtl/core_pipe_exec_mdu_issue.sv
// Execute-stage MDU initiator: issues one M-extension op, waits for the result (with watchdog),
// re-arms the MDU with a flush strobe and hands the result to writeback.
module core_pipe_exec_mdu_issue #(
   parameter int unsigned XLEN    = 64,
   parameter int unsigned TIMEOUT = 127
) (
   input  logic                       g_clk,
   input  logic                       g_resetn,
   input  logic                       flush,
   input  logic                       s_valid,
   output logic                       s_ready,
   input  logic [2:0]                 s_funct3,
   input  logic                       s_op_word,
   input  logic [XLEN-1:0]            s_rs1,
   input  logic [XLEN-1:0]            s_rs2,
   input  logic [4:0]                 s_rd_addr,
   core_pipe_exec_mdu_issue_if.master mdu,
   output logic                       m_valid,
   input  logic                       m_ready,
   output logic [4:0]                 m_rd_addr,
   output logic [XLEN-1:0]            m_rd_wdata,
   output logic                       busy,
   output logic                       timeout
);

   localparam logic [1:0] ST_IDLE = 2'd0;
   localparam logic [1:0] ST_RUN  = 2'd1;
   localparam logic [1:0] ST_CLR  = 2'd2;
   localparam logic [1:0] ST_OUT  = 2'd3;

   localparam logic [6:0] WDOG_MAX = 7'(TIMEOUT);

   logic [1:0]      state;
   logic [7:0]      op_q;      // one-hot, bit index == funct3
   logic            word_q;
   logic [XLEN-1:0] rs1_q;
   logic [XLEN-1:0] rs2_q;
   logic [4:0]      rd_q;
   logic [6:0]      wdog;
   logic            accept;

   assign s_ready = g_resetn && !flush &&
                    ((state == ST_IDLE) || ((state == ST_OUT) && m_ready));
   assign accept  = s_valid && s_ready;
   assign busy    = (state != ST_IDLE);

   always_ff @(posedge g_clk) begin
      if (!g_resetn) begin
         state      <= ST_IDLE;
         op_q       <= '0;
         word_q     <= 1'b0;
         rs1_q      <= '0;
         rs2_q      <= '0;
         rd_q       <= '0;
         wdog       <= '0;
         m_valid    <= 1'b0;
         m_rd_addr  <= '0;
         m_rd_wdata <= '0;
         timeout    <= 1'b0;
      end else if (flush) begin
         state   <= ST_IDLE;
         m_valid <= 1'b0;
      end else begin
         // accept can only fire from IDLE or OUT, so it never races the RUN watchdog update
         if (accept) begin
            op_q   <= 8'(1) << s_funct3;
            word_q <= s_op_word;
            rs1_q  <= s_rs1;
            rs2_q  <= s_rs2;
            rd_q   <= s_rd_addr;
            wdog   <= '0;
         end
         case (state)
            ST_IDLE: begin
               if (accept) state <= ST_RUN;
            end
            ST_RUN: begin
               wdog <= wdog + 7'd1;
               if (mdu.mdu_ready) begin
                  m_rd_wdata <= mdu.mdu_rd;
                  m_rd_addr  <= rd_q;
                  m_valid    <= 1'b1;
                  state      <= ST_CLR;
               end else if (wdog == WDOG_MAX) begin
                  m_rd_wdata <= '0;
                  m_rd_addr  <= rd_q;
                  m_valid    <= 1'b1;
                  timeout    <= 1'b1;
                  state      <= ST_CLR;
               end
            end
            ST_CLR: begin
               state <= ST_OUT;
            end
            default: begin
               if (m_ready) begin
                  m_valid <= 1'b0;
                  state   <= accept ? ST_RUN : ST_IDLE;
               end
            end
         endcase
      end
   end

   assign mdu.mdu_valid     = (state == ST_RUN) && !flush;
   assign mdu.mdu_flush     = flush || (state == ST_CLR);
   assign mdu.mdu_op_word   = word_q;
   assign mdu.mdu_op_mul    = op_q[0];
   assign mdu.mdu_op_mulh   = op_q[1];
   assign mdu.mdu_op_mulhsu = op_q[2];
   assign mdu.mdu_op_mulhu  = op_q[3];
   assign mdu.mdu_op_div    = op_q[4];
   assign mdu.mdu_op_divu   = op_q[5];
   assign mdu.mdu_op_rem    = op_q[6];
   assign mdu.mdu_op_remu   = op_q[7];
   assign mdu.mdu_rs1       = rs1_q;
   assign mdu.mdu_rs2       = rs2_q;

endmodule

// File: tb/tb_core_pipe_exec_mdu_issue.sv
// Randomized bench for core_pipe_exec_mdu_issue: stub MDU plus RISC-V M-extension reference model.
module tb_core_pipe_exec_mdu_issue;

   localparam int unsigned XLEN    = 64;
   localparam int unsigned TIMEOUT = 127;

   logic        g_clk = 1'b0;
   logic        g_resetn = 1'b0;
   logic        flush = 1'b0;
   logic        s_valid = 1'b0;
   logic        s_ready;
   logic [2:0]  s_funct3 = '0;
   logic        s_op_word = 1'b0;
   logic [63:0] s_rs1 = '0;
   logic [63:0] s_rs2 = '0;
   logic [4:0]  s_rd_addr = '0;
   logic        m_valid;
   logic        m_ready = 1'b0;
   logic [4:0]  m_rd_addr;
   logic [63:0] m_rd_wdata;
   logic        busy;
   logic        timeout;

   core_pipe_exec_mdu_issue_if #(.XLEN(XLEN)) mdu_if ();

   core_pipe_exec_mdu_issue #(.XLEN(XLEN), .TIMEOUT(TIMEOUT)) dut (
      .g_clk      (g_clk),
      .g_resetn   (g_resetn),
      .flush      (flush),
      .s_valid    (s_valid),
      .s_ready    (s_ready),
      .s_funct3   (s_funct3),
      .s_op_word  (s_op_word),
      .s_rs1      (s_rs1),
      .s_rs2      (s_rs2),
      .s_rd_addr  (s_rd_addr),
      .mdu        (mdu_if.master),
      .m_valid    (m_valid),
      .m_ready    (m_ready),
      .m_rd_addr  (m_rd_addr),
      .m_rd_wdata (m_rd_wdata),
      .busy       (busy),
      .timeout    (timeout)
   );

   always #5 g_clk = ~g_clk;

   int n_vec = 0;
   int n_err = 0;

   bit stub_en   = 1'b1;
   int stub_lat  = 2;
   bit stub_pend = 1'b0;
   int stub_cnt  = 0;

   task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_err++;
         $display("FAIL %s: got %h expected %h", tag, got, exp);
      end
   endtask

   // RISC-V M-extension result; *W forms operate on the low 32 bits and sign-extend.
   function automatic logic [63:0] ref_mdu(input logic [2:0] f3, input logic w,
                                           input logic [63:0] a, input logic [63:0] b);
      logic         sa, sb;
      logic [63:0]  x, y, r;
      logic [127:0] p;
      sa = (f3 == 3'd1) || (f3 == 3'd2) || (f3 == 3'd4) || (f3 == 3'd6);
      sb = (f3 == 3'd1) || (f3 == 3'd4) || (f3 == 3'd6);
      x = a;
      y = b;
      if (w) begin
         x = sa ? {{32{a[31]}}, a[31:0]} : {32'b0, a[31:0]};
         y = sb ? {{32{b[31]}}, b[31:0]} : {32'b0, b[31:0]};
         if (f3 == 3'd0) begin
            x = {32'b0, a[31:0]};
            y = {32'b0, b[31:0]};
         end
      end
      p = {{64{sa & x[63]}}, x} * {{64{sb & y[63]}}, y};
      case (f3)
         3'd0:    r = p[63:0];
         3'd1, 3'd2, 3'd3: r = p[127:64];
         3'd4: begin
            if (y == 64'd0) r = '1;
            else if (x == 64'h8000_0000_0000_0000 && y == '1) r = x;
            else r = $signed(x) / $signed(y);
         end
         3'd5:    r = (y == 64'd0) ? '1 : x / y;
         3'd6: begin
            if (y == 64'd0) r = x;
            else if (x == 64'h8000_0000_0000_0000 && y == '1) r = '0;
            else r = $signed(x) % $signed(y);
         end
         default: r = (y == 64'd0) ? x : x % y;
      endcase
      if (w) r = {{32{r[31]}}, r[31:0]};
      return r;
   endfunction

   // Stub MDU: answers stub_lat cycles into a request, holds the result until flushed.
   always begin
      logic [7:0] oh;
      logic [2:0] f3;
      @(posedge g_clk);
      #2;
      if (mdu_if.mdu_flush) begin
         mdu_if.mdu_ready = 1'b0;
         mdu_if.mdu_rd    = {$urandom, $urandom};
         stub_pend        = 1'b0;
      end else if (mdu_if.mdu_valid && !mdu_if.mdu_ready && stub_en) begin
         if (!stub_pend) begin
            stub_pend = 1'b1;
            stub_cnt  = stub_lat;
         end
         if (stub_cnt == 0) begin
            oh = {mdu_if.mdu_op_remu, mdu_if.mdu_op_rem, mdu_if.mdu_op_divu, mdu_if.mdu_op_div,
                  mdu_if.mdu_op_mulhu, mdu_if.mdu_op_mulhsu, mdu_if.mdu_op_mulh, mdu_if.mdu_op_mul};
            f3 = '0;
            for (int i = 0; i < 8; i++) if (oh[i]) f3 = 3'(i);
            mdu_if.mdu_rd    = ref_mdu(f3, mdu_if.mdu_op_word, mdu_if.mdu_rs1, mdu_if.mdu_rs2);
            mdu_if.mdu_ready = 1'b1;
            stub_pend        = 1'b0;
         end else begin
            stub_cnt--;
         end
      end
   end

   task automatic do_reset();
      @(negedge g_clk);
      g_resetn = 1'b0;
      s_valid  = 1'b0;
      flush    = 1'b0;
      m_ready  = 1'b0;
      repeat (2) @(negedge g_clk);
      mdu_if.mdu_ready = 1'b0;
      stub_pend        = 1'b0;
      check_eq("rst_m_valid", m_valid, 0);
      check_eq("rst_busy", busy, 0);
      check_eq("rst_timeout", timeout, 0);
      check_eq("rst_wdata", m_rd_wdata, 0);
      check_eq("rst_addr", m_rd_addr, 0);
      check_eq("rst_s_ready", s_ready, 0);
      check_eq("rst_mdu_valid", mdu_if.mdu_valid, 0);
      check_eq("rst_rs1", mdu_if.mdu_rs1, 0);
      check_eq("rst_op_div", mdu_if.mdu_op_div, 0);
      g_resetn = 1'b1;
   endtask

   // Offer an op; returns at the first negedge of RUN with s_valid dropped.
   task automatic issue(input logic [2:0] f3, input logic w, input logic [63:0] a,
                        input logic [63:0] b, input logic [4:0] rd);
      int k;
      @(negedge g_clk);
      s_funct3 = f3; s_op_word = w; s_rs1 = a; s_rs2 = b; s_rd_addr = rd;
      s_valid = 1'b1;
      k = 0;
      while (!s_ready && k < 300) begin
         @(negedge g_clk);
         k++;
      end
      if (!s_ready) begin
         check_eq("accept_wait", 0, 1);
         s_valid = 1'b0;
         return;
      end
      @(negedge g_clk);
      s_valid = 1'b0;
      check_eq("run_mdu_valid", mdu_if.mdu_valid, 1);
      check_eq("run_busy", busy, 1);
      check_eq("run_rs1", mdu_if.mdu_rs1, a);
      check_eq("run_rs2", mdu_if.mdu_rs2, b);
      check_eq("run_word", mdu_if.mdu_op_word, w);
      check_eq("run_onehot", {mdu_if.mdu_op_remu, mdu_if.mdu_op_rem, mdu_if.mdu_op_divu,
               mdu_if.mdu_op_div, mdu_if.mdu_op_mulhu, mdu_if.mdu_op_mulhsu,
               mdu_if.mdu_op_mulh, mdu_if.mdu_op_mul}, 64'(8'(1) << f3));
   endtask

   // Wait for the result, check the flush strobe, hold off writeback, then complete the beat.
   task automatic finish_op(input logic [63:0] exp_data, input logic [4:0] exp_addr,
                            input int hold, input bit early);
      int  k;
      bit  prev_ready;
      m_ready = early;
      k = 0;
      prev_ready = 1'b0;
      while (!m_valid && k < 400) begin
         prev_ready = mdu_if.mdu_ready;
         @(negedge g_clk);
         k++;
      end
      if (!m_valid) begin
         check_eq("result_wait", 0, 1);
         return;
      end
      check_eq("capture_one_cycle", prev_ready, 1);
      check_eq("clr_mdu_flush", mdu_if.mdu_flush, 1);
      check_eq("clr_mdu_valid", mdu_if.mdu_valid, 0);
      check_eq("clr_s_ready", s_ready, 0);
      @(negedge g_clk);
      check_eq("out_mdu_flush", mdu_if.mdu_flush, 0);
      check_eq("out_m_valid", m_valid, 1);
      check_eq("out_wdata", m_rd_wdata, exp_data);
      check_eq("out_addr", m_rd_addr, exp_addr);
      if (hold > 0) begin
         m_ready = 1'b0;
         repeat (hold) begin
            @(negedge g_clk);
            check_eq("hold_m_valid", m_valid, 1);
            check_eq("hold_wdata", m_rd_wdata, exp_data);
            check_eq("hold_addr", m_rd_addr, exp_addr);
            check_eq("hold_s_ready", s_ready, 0);
         end
      end
      m_ready = 1'b1;
      #1;
      check_eq("out_s_ready", s_ready, 1);
      @(negedge g_clk);
      m_ready = 1'b0;
      check_eq("done_m_valid", m_valid, 0);
      check_eq("done_busy", busy, 0);
   endtask

   function automatic logic [63:0] pick_operand();
      case ($urandom_range(0, 5))
         0:       return 64'd0;
         1:       return '1;
         2:       return 64'h8000_0000_0000_0000;
         3:       return 64'($urandom_range(0, 20));
         default: return {$urandom, $urandom};
      endcase
   endfunction

   initial begin
      #2_000_000;
      $display("FAIL global_timeout: simulation did not reach summary");
      $fatal(1);
   end

   initial begin
      logic [2:0]  f3;
      logic        w;
      logic [63:0] a, b;
      logic [4:0]  rd;
      int          n;

      mdu_if.mdu_ready = 1'b0;
      mdu_if.mdu_rd    = '0;
      do_reset();

      // Directed cases from the block's intended use
      stub_lat = 1;
      issue(3'd0, 1'b1, 64'd3, 64'd5, 5'd11);
      finish_op(64'd15, 5'd11, 0, 1'b0);
      issue(3'd5, 1'b0, 64'd7, 64'd0, 5'd3);
      finish_op('1, 5'd3, 0, 1'b1);
      issue(3'd6, 1'b0, -64'sd7, 64'd2, 5'd4);
      finish_op(ref_mdu(3'd6, 1'b0, -64'sd7, 64'd2), 5'd4, 20, 1'b0);
      check_eq("rem_neg7_2", ref_mdu(3'd6, 1'b0, -64'sd7, 64'd2), '1);

      // Back-to-back with s_valid held: second op accepted in the OUT cycle
      m_ready = 1'b1;
      issue(3'd0, 1'b0, 64'd3, 64'd5, 5'd7);
      s_funct3 = 3'd0; s_op_word = 1'b0; s_rs1 = 64'd6; s_rs2 = 64'd7; s_rd_addr = 5'd9;
      s_valid = 1'b1;
      n = 0;
      while (!m_valid && n < 100) begin
         @(negedge g_clk);
         n++;
      end
      check_eq("b2b_clr_flush", mdu_if.mdu_flush, 1);
      check_eq("b2b_clr_s_ready", s_ready, 0);
      @(negedge g_clk);
      check_eq("b2b_first_data", m_rd_wdata, 64'd15);
      check_eq("b2b_first_addr", m_rd_addr, 5'd7);
      check_eq("b2b_out_s_ready", s_ready, 1);
      @(negedge g_clk);
      s_valid = 1'b0;
      check_eq("b2b_m_valid_low", m_valid, 0);
      check_eq("b2b_rerun", mdu_if.mdu_valid, 1);
      check_eq("b2b_rs1", mdu_if.mdu_rs1, 64'd6);
      finish_op(64'd42, 5'd9, 0, 1'b1);

      // Flush 10 cycles into a long divide, with a coincident offer that must be refused
      stub_lat = 50;
      issue(3'd4, 1'b0, 64'd1000, 64'd7, 5'd2);
      repeat (9) @(negedge g_clk);
      flush = 1'b1;
      s_valid = 1'b1;
      #1;
      check_eq("flush_mdu_flush", mdu_if.mdu_flush, 1);
      check_eq("flush_mdu_valid", mdu_if.mdu_valid, 0);
      check_eq("flush_s_ready", s_ready, 0);
      @(negedge g_clk);
      flush = 1'b0;
      s_valid = 1'b0;
      check_eq("flush_idle", busy, 0);
      repeat (4) begin
         @(negedge g_clk);
         check_eq("flush_no_m_valid", m_valid, 0);
         check_eq("flush_stay_idle", busy, 0);
      end
      stub_lat = 2;
      issue(3'd0, 1'b0, 64'd2, 64'd2, 5'd5);
      finish_op(64'd4, 5'd5, 0, 1'b0);
      check_eq("timeout_clear", timeout, 0);

      // Randomized ops against the reference model
      for (int i = 0; i < 40; i++) begin
         f3 = 3'($urandom_range(0, 7));
         w  = 1'($urandom_range(0, 1));
         a  = pick_operand();
         b  = pick_operand();
         rd = 5'($urandom_range(0, 31));
         stub_lat = $urandom_range(0, 6);
         issue(f3, w, a, b, rd);
         finish_op(ref_mdu(f3, w, a, b), rd, $urandom_range(0, 3), 1'($urandom_range(0, 1)));
      end

      // Watchdog: RUN lasts TIMEOUT+1 cycles, result with zero data visible the cycle after
      stub_en = 1'b0;
      issue(3'd1, 1'b0, 64'd9, 64'd9, 5'd30);
      n = 1;
      while (!m_valid && n < 400) begin
         @(negedge g_clk);
         n++;
      end
      check_eq("wdog_cycles", 64'(n), 64'(TIMEOUT + 2));
      check_eq("wdog_data", m_rd_wdata, 0);
      check_eq("wdog_sticky_set", timeout, 1);
      @(negedge g_clk);
      m_ready = 1'b1;
      @(negedge g_clk);
      m_ready = 1'b0;
      check_eq("wdog_done", m_valid, 0);
      stub_en = 1'b1;
      issue(3'd7, 1'b0, 64'd17, 64'd5, 5'd1);
      finish_op(64'd2, 5'd1, 1, 1'b0);
      check_eq("wdog_sticky_hold", timeout, 1);

      // Reset in the middle of an op clears everything, including the sticky flag
      stub_lat = 40;
      issue(3'd4, 1'b0, 64'd100, 64'd3, 5'd6);
      repeat (3) @(negedge g_clk);
      do_reset();
      stub_lat = 0;
      issue(3'd3, 1'b0, '1, '1, 5'd8);
      finish_op(ref_mdu(3'd3, 1'b0, '1, '1), 5'd8, 0, 1'b0);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
      $finish;
   end

endmodule
